// File: rtl/cyclone86_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cyclone86_mem_pkg
//  Description : Shared types and sizes for the cyclone86 RAM bus. Holds the
//                RAM geometry, the arbiter state encoding and the grant
//                encoding used by the bus arbiter and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package cyclone86_mem_pkg;

    localparam int RAM_ADDR_W = 20;     // 1 MiB byte-addressed RAM
    localparam int RAM_DATA_W = 8;      // byte-wide data path

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ADDR = 3'd1,
        CPU_DATA = 3'd2,
        VID_ADDR = 3'd3,
        VID_DATA = 3'd4
    } state_t;

    // Which requester owns (or last owned) the bus
    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_VID = 1'b1
    } grant_t;

endpackage : cyclone86_mem_pkg
`default_nettype wire

// File: rtl/mem_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : mem_rr_pick2
//  Description : Combinational two-way round-robin picker. A lone requester
//                always wins; on a tie the requester that did not win last
//                time is chosen.
//  Ports       : req[1:0]    in   request vector (bit 0 = CPU, bit 1 = VID)
//                last_grant  in   previous winner (grant_t encoding)
//                grant_valid out  at least one request is pending
//                grant_sel   out  selected requester (grant_t encoding)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_pick2
    import cyclone86_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_sel
);

    always_comb begin
        grant_valid = |req;
        grant_sel   = GNT_CPU;
        if (req == 2'b11) begin
            // Tie: hand the bus to whoever did not have it last.
            grant_sel = (last_grant == GNT_CPU) ? GNT_VID : GNT_CPU;
        end else if (req[1]) begin
            grant_sel = GNT_VID;
        end
    end

endmodule : mem_rr_pick2
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Shares the byte-wide 1 MiB system RAM between the CPU port
//                and a read-only video fetch port. Arbitration happens in
//                IDLE; each access then runs through an ADDR state (strobe
//                on the RAM) and, for reads, a DATA state (ready/ack pulse
//                with the returned byte).
//  Ports       : clock, reset                     clock / sync active-high reset
//                cpu_address, cpu_o_data,
//                cpu_rd, cpu_wr                   CPU request side
//                cpu_i_data, cpu_ready            CPU completion side
//                vid_address, vid_req             video request side
//                vid_data, vid_ack                video completion side
//                mem_address, mem_o_data,
//                mem_rd, mem_wr, mem_i_data       RAM interface
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import cyclone86_mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_o_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_i_data,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] vid_address,
    input  logic              vid_req,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_o_data,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_i_data
);

    state_t              state_q,       state_d;
    grant_t              last_grant_q,  last_grant_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_o_data_q,  mem_o_data_d;
    logic                mem_rd_q,      mem_rd_d;
    logic                mem_wr_q,      mem_wr_d;
    logic [DATA_W-1:0]   cpu_i_data_q,  cpu_i_data_d;
    logic                cpu_ready_q,   cpu_ready_d;
    logic [DATA_W-1:0]   vid_data_q,    vid_data_d;
    logic                vid_ack_q,     vid_ack_d;

    logic                grant_valid;
    logic                grant_sel;

    mem_rr_pick2 u_pick (
        .req         ({vid_req, cpu_rd | cpu_wr}),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    // All outputs are registered: the values computed here for the next
    // state are the values that are visible while that state is current.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        mem_address_d = mem_address_q;
        mem_o_data_d  = mem_o_data_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        cpu_i_data_d  = cpu_i_data_q;
        cpu_ready_d   = 1'b0;
        vid_data_d    = vid_data_q;
        vid_ack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_t'(grant_sel) == GNT_CPU) begin
                        state_d       = CPU_ADDR;
                        last_grant_d  = GNT_CPU;
                        mem_address_d = cpu_address;
                        // Write wins when rd and wr are both raised.
                        if (cpu_wr) begin
                            mem_wr_d     = 1'b1;
                            mem_o_data_d = cpu_o_data;
                            cpu_ready_d  = 1'b1;
                        end else begin
                            mem_rd_d     = 1'b1;
                        end
                    end else begin
                        state_d       = VID_ADDR;
                        last_grant_d  = GNT_VID;
                        mem_address_d = vid_address;
                        mem_rd_d      = 1'b1;
                    end
                end
            end
            CPU_ADDR: begin
                // The latched write strobe tells us which kind of access
                // is in flight; writes are already complete.
                if (mem_wr_q) begin
                    state_d = IDLE;
                end else begin
                    state_d      = CPU_DATA;
                    cpu_i_data_d = mem_i_data;
                    cpu_ready_d  = 1'b1;
                end
            end
            CPU_DATA: begin
                state_d = IDLE;
            end
            VID_ADDR: begin
                state_d    = VID_DATA;
                vid_data_d = mem_i_data;
                vid_ack_d  = 1'b1;
            end
            VID_DATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GNT_VID;   // CPU wins the first tie
            mem_address_q <= '0;
            mem_o_data_q  <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            cpu_i_data_q  <= '0;
            cpu_ready_q   <= 1'b0;
            vid_data_q    <= '0;
            vid_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            mem_address_q <= mem_address_d;
            mem_o_data_q  <= mem_o_data_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            cpu_i_data_q  <= cpu_i_data_d;
            cpu_ready_q   <= cpu_ready_d;
            vid_data_q    <= vid_data_d;
            vid_ack_q     <= vid_ack_d;
        end
    end

    // Reset asserted mid-access must abort it in that very cycle: a strobe
    // or completion pulse already sitting in its register is masked so the
    // RAM never sees the write and the requester never sees the pulse.
    assign mem_rd      = mem_rd_q    & ~reset;
    assign mem_wr      = mem_wr_q    & ~reset;
    assign cpu_ready   = cpu_ready_q & ~reset;
    assign vid_ack     = vid_ack_q   & ~reset;

    assign mem_address = mem_address_q;
    assign mem_o_data  = mem_o_data_q;
    assign cpu_i_data  = cpu_i_data_q;
    assign vid_data    = vid_data_q;

endmodule : mem_bus_arbiter
`default_nettype wire
